// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - serial program loader that writes, checksums and read-back verifies an instruction image
//
// Purpose: receives a byte stream {len_lo, len_hi, N*4 data bytes, checksum},
// writes N little-endian words into instruction memory starting at BASE_ADDR,
// checks the 8-bit byte checksum, then reads every word back and compares the
// readback byte sum before reporting done. The CPU is held for the whole load.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start_i         begin a load (honoured only in IDLE, DONE, ERR)
//   rx_data_i/rx_valid_i/rx_ready_o   byte stream handshake
//   dm_we_o/dm_addr_o/dm_wdata_o/dm_rdata_i   instruction memory port
//   hold_o          CPU hold request
//   done_o, err_o, err_code_o   completion status (0 len, 1 timeout, 2 csum, 3 verify)
//   word_cnt_o      words written in the current or last load
module prog_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MAX_WORDS = 4096,
   parameter int          TIMEOUT   = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        rx_ready_o,
   output logic        dm_we_o,
   output logic [31:0] dm_addr_o,
   output logic [31:0] dm_wdata_o,
   input  logic [31:0] dm_rdata_i,
   output logic        hold_o,
   output logic        done_o,
   output logic        err_o,
   output logic [1:0]  err_code_o,
   output logic [15:0] word_cnt_o
);

   typedef enum logic [3:0] {
      IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, VERIFY, DONE, ERR
   } state_t;

   localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT - 1);

   state_t      state;
   logic [15:0] len_n;
   logic [15:0] word_cnt;
   logic [15:0] idx;
   logic [31:0] word_buf;
   logic [31:0] idle_cnt;
   logic [1:0]  byte_idx;
   logic [1:0]  err_code;
   logic [7:0]  sum_s;
   logic [7:0]  sum_r;

   logic        accept;
   logic [15:0] len_next;
   logic        len_bad;
   logic [7:0]  csum_total;
   logic [7:0]  r_next;

   assign rx_ready_o = (state == LEN_LO) || (state == LEN_HI) ||
                       (state == DATA)   || (state == CSUM);
   assign accept     = rx_valid_i && rx_ready_o;

   // Length is judged on the high byte as it arrives so the error is visible
   // on the very next cycle.
   assign len_next   = {rx_data_i, len_n[7:0]};
   assign len_bad    = (len_next == 16'd0) || ({1'b0, len_next} > 17'(MAX_WORDS));
   assign csum_total = sum_s + rx_data_i;
   assign r_next     = sum_r + dm_rdata_i[7:0] + dm_rdata_i[15:8] +
                       dm_rdata_i[23:16] + dm_rdata_i[31:24];

   assign hold_o     = !((state == IDLE) || (state == DONE) || (state == ERR));
   assign done_o     = (state == DONE);
   assign err_o      = (state == ERR);
   assign err_code_o = err_code;
   assign word_cnt_o = word_cnt;
   assign dm_we_o    = (state == WRITE);
   assign dm_wdata_o = (state == WRITE) ? word_buf : 32'd0;

   always_comb begin
      dm_addr_o = 32'd0;
      if (state == WRITE)
         dm_addr_o = BASE_ADDR + {14'd0, word_cnt, 2'b00};
      else if (state == VERIFY)
         dm_addr_o = BASE_ADDR + {14'd0, idx, 2'b00};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         len_n    <= 16'd0;
         word_cnt <= 16'd0;
         idx      <= 16'd0;
         word_buf <= 32'd0;
         idle_cnt <= 32'd0;
         byte_idx <= 2'd0;
         err_code <= 2'd0;
         sum_s    <= 8'd0;
         sum_r    <= 8'd0;
      end else begin
         case (state)
            IDLE, DONE, ERR: begin
               if (start_i) begin
                  state    <= LEN_LO;
                  word_cnt <= 16'd0;
                  idx      <= 16'd0;
                  idle_cnt <= 32'd0;
                  byte_idx <= 2'd0;
                  err_code <= 2'd0;
                  sum_s    <= 8'd0;
                  sum_r    <= 8'd0;
               end
            end
            default: begin
               // Idle counter only advances while a byte could be taken; it
               // holds through WRITE and VERIFY.
               if (rx_ready_o) begin
                  if (accept)
                     idle_cnt <= 32'd0;
                  else if (idle_cnt == TIMEOUT_M1) begin
                     state    <= ERR;
                     err_code <= 2'd1;
                  end else
                     idle_cnt <= idle_cnt + 32'd1;
               end
               case (state)
                  LEN_LO: if (accept) begin
                     len_n[7:0] <= rx_data_i;
                     state      <= LEN_HI;
                  end
                  LEN_HI: if (accept) begin
                     len_n[15:8] <= rx_data_i;
                     if (len_bad) begin
                        state    <= ERR;
                        err_code <= 2'd0;
                     end else
                        state <= DATA;
                  end
                  DATA: if (accept) begin
                     word_buf[{byte_idx, 3'b000} +: 8] <= rx_data_i;
                     sum_s    <= sum_s + rx_data_i;
                     byte_idx <= byte_idx + 2'd1;
                     if (byte_idx == 2'd3)
                        state <= WRITE;
                  end
                  WRITE: begin
                     word_cnt <= word_cnt + 16'd1;
                     state    <= (word_cnt + 16'd1 == len_n) ? CSUM : DATA;
                  end
                  CSUM: if (accept) begin
                     if (csum_total != 8'd0) begin
                        state    <= ERR;
                        err_code <= 2'd2;
                     end else begin
                        state <= VERIFY;
                        idx   <= 16'd0;
                        sum_r <= 8'd0;
                     end
                  end
                  VERIFY: begin
                     sum_r <= r_next;
                     if (idx == len_n - 16'd1) begin
                        if (r_next == sum_s)
                           state <= DONE;
                        else begin
                           state    <= ERR;
                           err_code <= 2'd3;
                        end
                     end else
                        idx <= idx + 16'd1;
                  end
                  default: ;
               endcase
            end
         endcase
      end
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
REQ-002 Parameter MAX_WORDS, 4096, largest accepted word count.
REQ-003 Parameter TIMEOUT, 1000000, idle cycles allowed between accepted bytes.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 start_i  in  1  pulse that begins a load; sampled only in IDLE, DONE, ERR.
REQ-007 rx_data_i  in  8  incoming byte.
REQ-008 rx_valid_i  in  1  rx_data_i valid.
REQ-009 rx_ready_o  out  1  loader accepts a byte this cycle.
REQ-010 dm_we_o  out  1  instruction-memory write enable.
REQ-011 dm_addr_o  out  32  instruction-memory byte address, write or read.
REQ-012 dm_wdata_o  out  32  instruction-memory write data.
REQ-013 dm_rdata_i  in  32  instruction-memory read data, combinational from dm_addr_o.
REQ-014 hold_o  out  1  CPU hold request.
REQ-015 done_o  out  1  load completed and verified.
REQ-016 err_o  out  1  load failed.
REQ-017 err_code_o  out  2  failure cause: 0 bad length, 1 timeout, 2 checksum, 3 verify.
REQ-018 word_cnt_o  out  16  number of words written in the current or last load.

Function
REQ-019 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, CSUM, VERIFY, DONE, ERR.
REQ-020 A byte SHALL be accepted only in a cycle where rx_valid_i and rx_ready_o are both 1.
REQ-021 rx_ready_o SHALL be 1 only in LEN_LO, LEN_HI, DATA and CSUM.
REQ-022 start_i in IDLE, DONE or ERR SHALL clear word_cnt_o, the sums, done_o and err_o, and go to LEN_LO.
REQ-023 hold_o SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-024 Length N SHALL be {LEN_HI byte, LEN_LO byte}, 16-bit little-endian.
REQ-025 N==0 or N>MAX_WORDS SHALL cause ERR with code 0 on the cycle after the LEN_HI byte is accepted.
REQ-026 DATA SHALL assemble 4 bytes little-endian (first byte to bits 7:0), then go to WRITE.
REQ-027 Each data byte SHALL be added to an 8-bit wrapping sum S.
REQ-028 WRITE SHALL last exactly one cycle.
REQ-029 In WRITE: dm_we_o=1, dm_addr_o=BASE_ADDR+4*word_cnt_o, dm_wdata_o=assembled word; word_cnt_o increments at the end of that cycle.
REQ-030 After WRITE the loader SHALL go to CSUM if N words are written, else back to DATA.
REQ-031 CSUM SHALL accept one byte C; (S+C) mod 256 != 0 goes to ERR code 2, else to VERIFY with index 0 and readback sum R=0.
REQ-032 VERIFY SHALL read one word per cycle: dm_we_o=0, dm_addr_o=BASE_ADDR+4*index, and add the 4 bytes of dm_rdata_i to the 8-bit sum R.
REQ-033 After index N-1, R (including that word) != S goes to ERR code 3, else to DONE; VERIFY lasts exactly N cycles.
REQ-034 dm_we_o SHALL be 0 in every state except WRITE.
REQ-035 dm_addr_o and dm_wdata_o SHALL be 0 in states other than WRITE and VERIFY.
REQ-036 A 32-bit idle counter SHALL run while rx_ready_o=1 and clear on each accepted byte; reaching TIMEOUT goes to ERR code 1.
REQ-037 DONE and ERR SHALL hold done_o or err_o (and err_code_o) at 1 until the next start_i or reset.
REQ-038 start_i outside IDLE, DONE and ERR SHALL be ignored.
REQ-039 Address arithmetic SHALL be 32-bit and wrap modulo 2^32.

Reset
REQ-040 Reset assertion SHALL immediately force IDLE and set every output to 0, including hold_o, even mid-load.
REQ-041 A partially loaded image SHALL NOT be resumed after reset.

Verification
REQ-042 BASE=0; start, bytes 02 00 13 00 00 00 EF BE AD DE B5 -> writes 0x00000013@0x0 and 0xDEADBEEF@0x4, 2 VERIFY cycles, done_o=1, word_cnt_o=2, hold_o=0.
REQ-043 Same stream with checksum byte B4 -> err_o=1, err_code_o=2, exactly 2 writes issued, no VERIFY cycles.
REQ-044 Stream length bytes 00 00, then separately 01 10 (N=4097) -> err_code_o=0 each time, no writes.
REQ-045 Memory model corrupts word 1 on readback -> err_code_o=3 after 2 VERIFY cycles.
REQ-046 TIMEOUT=16; rx_valid_i stays low after the first data byte -> err_code_o=1 at idle count 16; stalls of 15 cycles between bytes still complete.
REQ-047 Reset asserted mid-DATA -> all outputs 0 asynchronously; a new start then loads a full image correctly.
